coeff_sp_sram: RTL

//   Single-port coefficient memory answering the FIR control FSM's CsN/WrN/Addr/WtDt interface.

---
 rtl/coeff_sp_sram.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/coeff_sp_sram.sv
// ---------------------------------------------------------------------------
// coeff_sp_sram
//
// Single-port coefficient memory for the FIR control FSM. It holds one set of
// P_NUM_TAPS coefficients for each of P_NUM_BANKS FIR modules. iModuleSel
// picks the bank. After reset the block clears every word with a zero sweep,
// one word per cycle, before it accepts any access.
//
// Optional feature (macro COEFF_PARITY_EN):
//   When the macro is defined, each word also stores an even-parity bit.
//   Every read rechecks that bit, and a mismatch sets the sticky flag
//   oParErr. The input iParInj inverts the stored parity bit on a write,
//   which lets a test inject a fault.
//   When the macro is undefined, the block has no parity storage and no
//   oParErr / iParInj ports.
//
// Ports
//   iClk12M      in   system clock, rising edge
//   iRsn         in   synchronous reset, active-low
//   iCsnRam      in   chip select, active-low
//   iWrnRam      in   0 = write, 1 = read
//   iAddrRam     in   word address within bank
//   iModuleSel   in   bank select
//   iWtDtRam     in   write data
//   iClrErr      in   pulse, clears sticky error flags
//   iParInj      in   (COEFF_PARITY_EN) invert stored parity on write
//   oRdDtRam     out  registered read data
//   oRdDtValid   out  oRdDtRam holds data of a read accepted last cycle
//   oInitDone    out  zero sweep complete, accesses accepted
//   oBankLoaded  out  bit b = every word of bank b written since reset
//   oAccErr      out  sticky: access dropped (out of range or during init)
//   oParErr      out  (COEFF_PARITY_EN) sticky: parity mismatch on a read
//   oFsmState    out  debug view of the controller state (0 INIT, 1 READY)
//
// Handshake: there is no back-pressure. A request is the cycle on which
// iCsnRam=0. A read that is accepted at edge N shows oRdDtValid=1 with its
// data after edge N, for exactly one cycle. A dropped read and an idle cycle
// both leave oRdDtValid=0.
// ---------------------------------------------------------------------------
module coeff_sp_sram #(
  parameter int P_DATA_W    = 16,
  parameter int P_ADDR_W    = 4,
  parameter int P_NUM_TAPS  = 11,
  parameter int P_NUM_BANKS = 4
) (
  input  logic                           iClk12M,
  input  logic                           iRsn,
  input  logic                           iCsnRam,
  input  logic                           iWrnRam,
  input  logic [P_ADDR_W-1:0]            iAddrRam,
  input  logic [$clog2(P_NUM_BANKS)-1:0] iModuleSel,
  input  logic [P_DATA_W-1:0]            iWtDtRam,
  input  logic                           iClrErr,
`ifdef COEFF_PARITY_EN
  input  logic                           iParInj,
  output logic                           oParErr,
`endif
  output logic [P_DATA_W-1:0]            oRdDtRam,
  output logic                           oRdDtValid,
  output logic                           oInitDone,
  output logic [P_NUM_BANKS-1:0]         oBankLoaded,
  output logic                           oAccErr,
  output logic                           oFsmState
);

  localparam int L_WORDS = P_NUM_BANKS * P_NUM_TAPS;
  localparam int L_IDX_W = $clog2(L_WORDS);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [L_IDX_W-1:0]   r_sweep;
  logic [P_DATA_W-1:0]  r_mem [L_WORDS];
  logic [P_NUM_TAPS-1:0] r_mask [P_NUM_BANKS];
  logic [P_DATA_W-1:0]  r_rd_data;
  logic                 r_rd_valid;
  logic                 r_init_done;
  logic                 r_acc_err;

  logic                 w_acc_req;
  logic                 w_addr_ok;
  logic [L_IDX_W-1:0]   w_acc_idx;
  logic                 w_init_wr;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_rd_bad;
  logic                 w_err_new;
  logic                 w_mem_we;
  logic [L_IDX_W-1:0]   w_mem_idx;
  logic [P_DATA_W-1:0]  w_mem_wdata;

  // Flat word index: the banks are stored back to back. Because the zero
  // sweep walks the same bank-major order, the sweep counter can address the
  // array directly.
  assign w_acc_req = ~iCsnRam;
  assign w_addr_ok = (32'(iAddrRam) < P_NUM_TAPS);
  assign w_acc_idx = L_IDX_W'(iModuleSel) * L_IDX_W'(P_NUM_TAPS) + L_IDX_W'(iAddrRam);

  // -------------------------------------------------------------------------
  // Controller FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_wr_ok     = 1'b0;
    w_rd_ok     = 1'b0;
    w_rd_bad    = 1'b0;
    w_err_new   = 1'b0;
    case (r_state)
      ST_INIT: begin
        // The sweep owns the array, so any request during the sweep is dropped.
        w_init_wr = 1'b1;
        w_err_new = w_acc_req;
        if (r_sweep == L_IDX_W'(L_WORDS - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (w_acc_req) begin
          if (w_addr_ok) begin
            w_wr_ok = ~iWrnRam;
            w_rd_ok = iWrnRam;
          end else begin
            w_err_new = 1'b1;
            w_rd_bad  = iWrnRam;
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sweep counter. It stops on the last word, and READY never looks at it.
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_sweep <= '0;
    end else if (w_init_wr && (r_sweep != L_IDX_W'(L_WORDS - 1))) begin
      r_sweep <= r_sweep + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Array write port, shared by the sweep and by normal writes. The reset
  // gate stops a READY write from landing while iRsn is low.
  // -------------------------------------------------------------------------
  assign w_mem_we    = iRsn & (w_init_wr | w_wr_ok);
  assign w_mem_idx   = w_init_wr ? r_sweep : w_acc_idx;
  assign w_mem_wdata = w_init_wr ? '0 : iWtDtRam;

  always_ff @(posedge iClk12M) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Registered read port. A write commits at its edge, so a read on the
  // following cycle already sees the new word.
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[w_acc_idx];
      end else if (w_rd_bad) begin
        r_rd_data <= '0;
      end
    end
  end

  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  // -------------------------------------------------------------------------
  // Per-bank write masks. A rewrite leaves a bank loaded; only reset clears
  // the masks.
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      for (int b = 0; b < P_NUM_BANKS; b++) begin
        r_mask[b] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mask[iModuleSel][iAddrRam] <= 1'b1;
    end
  end

  always_comb begin
    oBankLoaded = '0;
    for (int b = 0; b < P_NUM_BANKS; b++) begin
      oBankLoaded[b] = &r_mask[b];
    end
  end

  // A new error beats a clear on the same cycle.
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_acc_err <= 1'b0;
    end else if (w_err_new) begin
      r_acc_err <= 1'b1;
    end else if (iClrErr) begin
      r_acc_err <= 1'b0;
    end
  end

`ifdef COEFF_PARITY_EN
  // -------------------------------------------------------------------------
  // Parity side array. Sweep zeros get a correct parity bit (0). iParInj
  // only affects normal writes.
  // -------------------------------------------------------------------------
  logic r_par [L_WORDS];
  logic r_par_err;
  logic w_par_bad;

  always_ff @(posedge iClk12M) begin
    if (w_mem_we) begin
      r_par[w_mem_idx] <= (^w_mem_wdata) ^ (w_wr_ok & iParInj);
    end
  end

  assign w_par_bad = w_rd_ok & ((^r_mem[w_acc_idx]) != r_par[w_acc_idx]);

  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_par_err <= 1'b0;
    end else if (w_par_bad) begin
      r_par_err <= 1'b1;
    end else if (iClrErr) begin
      r_par_err <= 1'b0;
    end
  end

  assign oParErr = r_par_err;
`endif

  assign oRdDtRam   = r_rd_data;
  assign oRdDtValid = r_rd_valid;
  assign oInitDone  = r_init_done;
  assign oAccErr    = r_acc_err;
  assign oFsmState  = r_state;

endmodule
